icache_refill: RTL and testbench

Instruction-cache miss/refill controller sitting directly upstream of the I-cache tag and data arrays. It accepts one line miss at a time and fetches the line from memory as `BEATS_PER_LINE` beats. It then writes tag, valid and data into one victim way in a single cycle through the arrays' write ports. After reset, and on request, it also invalidates every set in every way.

---
 rtl/icache_pkg.sv | 49 ++++
 rtl/icache_victim_rr.sv | 39 +++
 rtl/icache_refill.sv | 212 +++++++++++++++++++++
 tb/tb_icache_refill.sv | 426 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/icache_pkg.sv
// icache_pkg
//   Shared definitions for the I-cache refill controller: FSM state encoding,
//   default geometry, derived field widths and address-split helpers.
//   The helpers take a zero-extended address and return it shifted so that
//   the requested field sits at bit 0; callers truncate to the field width.
package icache_pkg;

  typedef enum logic [2:0] {
    S_INIT,
    S_IDLE,
    S_REQ,
    S_WAIT,
    S_WRITE,
    S_FLUSH
  } state_e;

  localparam int MAX_ADDR_W = 64;
  typedef logic [MAX_ADDR_W-1:0] addr_t;

  localparam int DEF_NUM_WAYS            = 4;
  localparam int DEF_NUM_BANKS           = 4;
  localparam int DEF_SETS_PER_BANK_WIDTH = 8;
  localparam int DEF_ADDR_WIDTH          = 32;
  localparam int DEF_BEAT_WIDTH          = 64;
  localparam int DEF_BEATS_PER_LINE      = 4;

  // Byte-offset bits inside one line.
  function automatic int offset_width(input int beats, input int beat_w);
    return $clog2(beats * beat_w / 8);
  endfunction

  localparam int OFFSET_W   = offset_width(DEF_BEATS_PER_LINE, DEF_BEAT_WIDTH);
  localparam int BANK_SEL_W = $clog2(DEF_NUM_BANKS);
  localparam int DEF_TAG_W  = DEF_ADDR_WIDTH - OFFSET_W - BANK_SEL_W - DEF_SETS_PER_BANK_WIDTH;

  function automatic addr_t get_bank(input addr_t a, input int off_w);
    return a >> off_w;
  endfunction

  function automatic addr_t get_set(input addr_t a, input int off_w, input int bank_w);
    return a >> (off_w + bank_w);
  endfunction

  function automatic addr_t get_tag(input addr_t a, input int off_w, input int bank_w,
                                    input int set_w);
    return a >> (off_w + bank_w + set_w);
  endfunction

endpackage

// File: rtl/icache_victim_rr.sv
// icache_victim_rr
//   One-hot round-robin victim way pointer. Resets to way 0 and rotates left
//   by one way (wrapping from the top way to way 0) on each advance pulse.
// Ports:
//   clk_i, rst_ni  clock, asynchronous active-low reset
//   advance_i      rotate the pointer at the next clock edge
//   victim_o       current one-hot victim way
module icache_victim_rr
  import icache_pkg::*;
#(
  parameter int NUM_WAYS = DEF_NUM_WAYS
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                advance_i,
  output logic [NUM_WAYS-1:0] victim_o
);

  logic [NUM_WAYS-1:0] victim_q;
  logic [NUM_WAYS-1:0] victim_d;

  always_comb begin
    victim_d = victim_q;
    if (advance_i) begin
      victim_d = (victim_q << 1) | (victim_q >> (NUM_WAYS - 1));
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      victim_q <= NUM_WAYS'(1);
    end else begin
      victim_q <= victim_d;
    end
  end

  assign victim_o = victim_q;

endmodule

// File: rtl/icache_refill.sv
// icache_refill
//   I-cache miss/refill controller. Takes one line miss at a time, reads the
//   line from memory as BEATS_PER_LINE beats, then writes tag, valid and data
//   into the round-robin victim way in a single cycle. After every reset, and
//   whenever flush_i is seen in IDLE, it invalidates every set of every way.
// Ports:
//   clk_i, rst_ni                         clock, asynchronous active-low reset
//   miss_valid_i/miss_ready_o/miss_addr_i miss request handshake
//   flush_i                               level request for a full invalidate
//   mem_req_valid_o/ready_i/addr_o        line-aligned memory read request
//   mem_rsp_valid_i/mem_rsp_data_i        in-order response beats
//   w_bank_addr_o/w_bank_sel_o            array write set and bank
//   we_way_mask_o                         per-way write enable
//   wdata_tag_o/valid_o/line_o            array write data
//   refill_done_o/flush_done_o            one-cycle completion pulses
//   busy_o                                controller not in IDLE
module icache_refill
  import icache_pkg::*;
#(
  parameter int NUM_WAYS            = DEF_NUM_WAYS,
  parameter int NUM_BANKS           = DEF_NUM_BANKS,
  parameter int SETS_PER_BANK_WIDTH = DEF_SETS_PER_BANK_WIDTH,
  parameter int ADDR_WIDTH          = DEF_ADDR_WIDTH,
  parameter int BEAT_WIDTH          = DEF_BEAT_WIDTH,
  parameter int BEATS_PER_LINE      = DEF_BEATS_PER_LINE,
  parameter int TAG_WIDTH           = DEF_TAG_W
) (
  input  logic                                 clk_i,
  input  logic                                 rst_ni,
  input  logic                                 miss_valid_i,
  output logic                                 miss_ready_o,
  input  logic [ADDR_WIDTH-1:0]                miss_addr_i,
  input  logic                                 flush_i,
  output logic                                 mem_req_valid_o,
  input  logic                                 mem_req_ready_i,
  output logic [ADDR_WIDTH-1:0]                mem_req_addr_o,
  input  logic                                 mem_rsp_valid_i,
  input  logic [BEAT_WIDTH-1:0]                mem_rsp_data_i,
  output logic [SETS_PER_BANK_WIDTH-1:0]       w_bank_addr_o,
  output logic [$clog2(NUM_BANKS)-1:0]         w_bank_sel_o,
  output logic [NUM_WAYS-1:0]                  we_way_mask_o,
  output logic [TAG_WIDTH-1:0]                 wdata_tag_o,
  output logic                                 wdata_valid_o,
  output logic [BEATS_PER_LINE*BEAT_WIDTH-1:0] wdata_line_o,
  output logic                                 refill_done_o,
  output logic                                 flush_done_o,
  output logic                                 busy_o
);

  localparam int BANK_W      = $clog2(NUM_BANKS);
  localparam int OFF_W       = offset_width(BEATS_PER_LINE, BEAT_WIDTH);
  localparam int BEAT_CNT_W  = (BEATS_PER_LINE > 1) ? $clog2(BEATS_PER_LINE) : 1;
  localparam int FLUSH_CNT_W = BANK_W + SETS_PER_BANK_WIDTH;
  localparam int LINE_W      = BEATS_PER_LINE * BEAT_WIDTH;

  localparam logic [BEAT_CNT_W-1:0]  LAST_BEAT  = BEAT_CNT_W'(BEATS_PER_LINE - 1);
  localparam logic [FLUSH_CNT_W-1:0] LAST_FLUSH = '1;
  localparam logic [ADDR_WIDTH-1:0]  LINE_MASK  = {ADDR_WIDTH{1'b1}} << OFF_W;

  if (TAG_WIDTH != ADDR_WIDTH - OFF_W - BANK_W - SETS_PER_BANK_WIDTH) begin : g_bad_tag_width
    $error("icache_refill: TAG_WIDTH does not match the address split");
  end

  state_e                        state_q, state_d;
  logic [ADDR_WIDTH-1:0]         miss_addr_q, miss_addr_d;
  logic [BEAT_CNT_W-1:0]         beat_cnt_q, beat_cnt_d;
  logic [FLUSH_CNT_W-1:0]        flush_cnt_q, flush_cnt_d;
  logic [LINE_W-1:0]             line_buf_q, line_buf_d;

  logic                          mem_req_valid_q, mem_req_valid_d;
  logic [SETS_PER_BANK_WIDTH-1:0] bank_addr_q, bank_addr_d;
  logic [BANK_W-1:0]             bank_sel_q, bank_sel_d;
  logic [NUM_WAYS-1:0]           we_mask_q, we_mask_d;
  logic [TAG_WIDTH-1:0]          tag_q, tag_d;
  logic                          wvalid_q, wvalid_d;
  logic [LINE_W-1:0]             line_q, line_d;
  logic                          refill_done_q, refill_done_d;
  logic                          flush_done_q, flush_done_d;
  logic                          busy_q, busy_d;

  logic [NUM_WAYS-1:0]           victim;
  logic                          victim_adv;

  assign victim_adv = (state_q == S_WRITE);

  icache_victim_rr #(
    .NUM_WAYS (NUM_WAYS)
  ) u_victim (
    .clk_i     (clk_i),
    .rst_ni    (rst_ni),
    .advance_i (victim_adv),
    .victim_o  (victim)
  );

  always_comb begin
    state_d     = state_q;
    miss_addr_d = miss_addr_q;
    beat_cnt_d  = beat_cnt_q;
    flush_cnt_d = flush_cnt_q;
    line_buf_d  = line_buf_q;

    case (state_q)
      S_INIT:  state_d = S_FLUSH;
      S_IDLE: begin
        if (flush_i) begin
          state_d = S_FLUSH;
        end else if (miss_valid_i) begin
          miss_addr_d = miss_addr_i;
          beat_cnt_d  = '0;
          state_d     = S_REQ;
        end
      end
      S_REQ: begin
        if (mem_req_ready_i) state_d = S_WAIT;
      end
      S_WAIT: begin
        if (mem_rsp_valid_i) begin
          line_buf_d[beat_cnt_q*BEAT_WIDTH +: BEAT_WIDTH] = mem_rsp_data_i;
          beat_cnt_d = beat_cnt_q + BEAT_CNT_W'(1);
          if (beat_cnt_q == LAST_BEAT) state_d = S_WRITE;
        end
      end
      S_WRITE: state_d = S_IDLE;
      S_FLUSH: begin
        // Wraps back to 0 on the last index, ready for the next flush.
        flush_cnt_d = flush_cnt_q + FLUSH_CNT_W'(1);
        if (flush_cnt_q == LAST_FLUSH) state_d = S_IDLE;
      end
      default: state_d = S_INIT;
    endcase

    // Outputs are registered: derive them from the state being entered so
    // they line up with that state in the following cycle. The victim only
    // advances at the end of WRITE, so its current value is the one to use.
    mem_req_valid_d = (state_d == S_REQ);
    busy_d          = (state_d != S_IDLE);
    refill_done_d   = (state_d == S_WRITE);
    wvalid_d        = (state_d == S_WRITE);
    flush_done_d    = (state_d == S_FLUSH) && (flush_cnt_d == LAST_FLUSH);
    we_mask_d       = '0;
    bank_addr_d     = '0;
    bank_sel_d      = '0;
    tag_d           = '0;
    line_d          = '0;
    if (state_d == S_WRITE) begin
      we_mask_d   = victim;
      bank_addr_d = SETS_PER_BANK_WIDTH'(get_set(addr_t'(miss_addr_q), OFF_W, BANK_W));
      bank_sel_d  = BANK_W'(get_bank(addr_t'(miss_addr_q), OFF_W));
      tag_d       = TAG_WIDTH'(get_tag(addr_t'(miss_addr_q), OFF_W, BANK_W,
                                       SETS_PER_BANK_WIDTH));
      line_d      = line_buf_d;
    end else if (state_d == S_FLUSH) begin
      we_mask_d   = '1;
      bank_addr_d = flush_cnt_d[SETS_PER_BANK_WIDTH-1:0];
      bank_sel_d  = flush_cnt_d[FLUSH_CNT_W-1 -: BANK_W];
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q         <= S_INIT;
      miss_addr_q     <= '0;
      beat_cnt_q      <= '0;
      flush_cnt_q     <= '0;
      line_buf_q      <= '0;
      mem_req_valid_q <= 1'b0;
      bank_addr_q     <= '0;
      bank_sel_q      <= '0;
      we_mask_q       <= '0;
      tag_q           <= '0;
      wvalid_q        <= 1'b0;
      line_q          <= '0;
      refill_done_q   <= 1'b0;
      flush_done_q    <= 1'b0;
      busy_q          <= 1'b1;
    end else begin
      state_q         <= state_d;
      miss_addr_q     <= miss_addr_d;
      beat_cnt_q      <= beat_cnt_d;
      flush_cnt_q     <= flush_cnt_d;
      line_buf_q      <= line_buf_d;
      mem_req_valid_q <= mem_req_valid_d;
      bank_addr_q     <= bank_addr_d;
      bank_sel_q      <= bank_sel_d;
      we_mask_q       <= we_mask_d;
      tag_q           <= tag_d;
      wvalid_q        <= wvalid_d;
      line_q          <= line_d;
      refill_done_q   <= refill_done_d;
      flush_done_q    <= flush_done_d;
      busy_q          <= busy_d;
    end
  end

  assign miss_ready_o    = (state_q == S_IDLE) && !flush_i;
  assign mem_req_valid_o = mem_req_valid_q;
  assign mem_req_addr_o  = miss_addr_q & LINE_MASK;
  assign w_bank_addr_o   = bank_addr_q;
  assign w_bank_sel_o    = bank_sel_q;
  assign we_way_mask_o   = we_mask_q;
  assign wdata_tag_o     = tag_q;
  assign wdata_valid_o   = wvalid_q;
  assign wdata_line_o    = line_q;
  assign refill_done_o   = refill_done_q;
  assign flush_done_o    = flush_done_q;
  assign busy_o          = busy_q;

  // Response beats are only legal while a line is being collected.
  a_rsp_only_in_wait : assert property (
    @(posedge clk_i) disable iff (!rst_ni) mem_rsp_valid_i |-> (state_q == S_WAIT));

endmodule

// File: tb/tb_icache_refill.sv
module tb_icache_refill;

  logic         clk = 1'b0;
  logic         rst_ni;
  logic         miss_valid_i;
  logic         miss_ready_o;
  logic [31:0]  miss_addr_i;
  logic         flush_i;
  logic         mem_req_valid_o;
  logic         mem_req_ready_i;
  logic [31:0]  mem_req_addr_o;
  logic         mem_rsp_valid_i;
  logic [63:0]  mem_rsp_data_i;
  logic [7:0]   w_bank_addr_o;
  logic [1:0]   w_bank_sel_o;
  logic [3:0]   we_way_mask_o;
  logic [16:0]  wdata_tag_o;
  logic         wdata_valid_o;
  logic [255:0] wdata_line_o;
  logic         refill_done_o;
  logic         flush_done_o;
  logic         busy_o;

  int n_vec = 0;
  int n_err = 0;

  logic [3:0]   exp_victim;
  int           obs_writes;
  logic [3:0]   obs_mask;
  logic [255:0] obs_line;
  logic [16:0]  obs_tag;
  logic [7:0]   obs_set;
  logic [1:0]   obs_bank;

  always #5 clk = ~clk;

  icache_refill dut (
    .clk_i           (clk),
    .rst_ni          (rst_ni),
    .miss_valid_i    (miss_valid_i),
    .miss_ready_o    (miss_ready_o),
    .miss_addr_i     (miss_addr_i),
    .flush_i         (flush_i),
    .mem_req_valid_o (mem_req_valid_o),
    .mem_req_ready_i (mem_req_ready_i),
    .mem_req_addr_o  (mem_req_addr_o),
    .mem_rsp_valid_i (mem_rsp_valid_i),
    .mem_rsp_data_i  (mem_rsp_data_i),
    .w_bank_addr_o   (w_bank_addr_o),
    .w_bank_sel_o    (w_bank_sel_o),
    .we_way_mask_o   (we_way_mask_o),
    .wdata_tag_o     (wdata_tag_o),
    .wdata_valid_o   (wdata_valid_o),
    .wdata_line_o    (wdata_line_o),
    .refill_done_o   (refill_done_o),
    .flush_done_o    (flush_done_o),
    .busy_o          (busy_o)
  );

  // Entry: at the negedge where flush index 0 is visible. Exit: first IDLE negedge.
  task automatic check_flush_sweep(input string tag);
    logic [36:0] obs;
    logic [36:0] exp;
    logic [9:0]  idx;
    for (int i = 0; i < 1024; i++) begin
      idx = i[9:0];
      obs = {we_way_mask_o, w_bank_sel_o, w_bank_addr_o, wdata_tag_o, wdata_valid_o,
             |wdata_line_o, flush_done_o, refill_done_o, miss_ready_o, busy_o};
      exp = {4'hf, idx[9:8], idx[7:0], 17'd0, 1'b0, 1'b0, (i == 1023), 1'b0, 1'b0, 1'b1};
      n_vec++;
      if (obs !== exp) begin
        n_err++;
        $display("FAIL %s_flush idx=%0d got=%h want=%h", tag, i, obs, exp);
      end
      @(negedge clk);
    end
    n_vec++;
    if ({busy_o, we_way_mask_o, flush_done_o} !== 6'b0) begin
      n_err++;
      $display("FAIL %s_flush_end busy/mask/done got=%b want=000000", tag,
               {busy_o, we_way_mask_o, flush_done_o});
    end
  endtask

  // Entry: at the negedge right after the miss handshake edge.
  task automatic finish_miss(input logic [63:0] b0);
    int i;
    i = 0;
    while (!mem_req_valid_o && i < 8) begin
      @(negedge clk);
      i++;
    end
    if (!mem_req_valid_o) begin
      n_vec++;
      n_err++;
      $display("FAIL req_timeout got mem_req_valid=0 want 1 within 8 cycles");
      obs_writes = 0;
    end else begin
      mem_req_ready_i = 1'b1;
      @(negedge clk);
      mem_req_ready_i = 1'b0;
      for (int k = 0; k < 4; k++) begin
        mem_rsp_valid_i = 1'b1;
        mem_rsp_data_i  = b0 + 64'(k);
        @(negedge clk);
      end
      mem_rsp_valid_i = 1'b0;
      obs_writes = 0;
      for (int k = 0; k < 3; k++) begin
        if (we_way_mask_o !== 4'b0) begin
          obs_writes++;
          obs_mask = we_way_mask_o;
          obs_line = wdata_line_o;
          obs_tag  = wdata_tag_o;
          obs_set  = w_bank_addr_o;
          obs_bank = w_bank_sel_o;
        end
        @(negedge clk);
      end
    end
  endtask

  task automatic drive_miss(input logic [31:0] addr, input logic [63:0] b0);
    miss_valid_i = 1'b1;
    miss_addr_i  = addr;
    @(negedge clk);
    miss_valid_i = 1'b0;
    finish_miss(b0);
  endtask

  task automatic test_reset();
    rst_ni = 1'b0;
    miss_valid_i = 1'b1;
    miss_addr_i = 32'h0;
    flush_i = 1'b0;
    mem_req_ready_i = 1'b0;
    mem_rsp_valid_i = 1'b0;
    mem_rsp_data_i = 64'h0;
    repeat (3) @(negedge clk);
    n_vec++;
    if ({busy_o, we_way_mask_o, mem_req_valid_o, miss_ready_o, refill_done_o, flush_done_o,
         wdata_valid_o} !== 10'b1_0000_00000) begin
      n_err++;
      $display("FAIL reset_ctrl got=%b want=1000000000", {busy_o, we_way_mask_o,
               mem_req_valid_o, miss_ready_o, refill_done_o, flush_done_o, wdata_valid_o});
    end
    n_vec++;
    if ({mem_req_addr_o, wdata_tag_o, w_bank_addr_o, w_bank_sel_o} !== 59'd0 ||
        wdata_line_o !== 256'd0) begin
      n_err++;
      $display("FAIL reset_data got addr=%h tag=%h set=%h bank=%h line=%h want all 0",
               mem_req_addr_o, wdata_tag_o, w_bank_addr_o, w_bank_sel_o, wdata_line_o);
    end
    miss_valid_i = 1'b0;
  endtask

  task automatic test_init_flush();
    rst_ni = 1'b1;
    #1;
    n_vec++;
    if ({busy_o, we_way_mask_o, miss_ready_o} !== 6'b100000) begin
      n_err++;
      $display("FAIL init_cycle got=%b want=100000", {busy_o, we_way_mask_o, miss_ready_o});
    end
    @(negedge clk);
    check_flush_sweep("init");
    n_vec++;
    if (miss_ready_o !== 1'b1) begin
      n_err++;
      $display("FAIL init_ready got=%b want=1", miss_ready_o);
    end
    exp_victim = 4'b0001;
  endtask

  task automatic test_refill();
    logic [63:0] beats [4];
    beats = '{64'h1111_1111_1111_1111, 64'h2222_2222_2222_2222,
              64'h3333_3333_3333_3333, 64'h4444_4444_4444_4444};
    miss_valid_i = 1'b1;
    miss_addr_i  = 32'h8000_1234;
    @(negedge clk);
    miss_valid_i = 1'b0;
    n_vec++;
    if ({mem_req_valid_o, miss_ready_o, busy_o} !== 3'b101 || mem_req_addr_o !== 32'h8000_1220) begin
      n_err++;
      $display("FAIL refill_req got v/r/b=%b addr=%h want 101 addr=80001220",
               {mem_req_valid_o, miss_ready_o, busy_o}, mem_req_addr_o);
    end
    mem_req_ready_i = 1'b1;
    @(negedge clk);
    mem_req_ready_i = 1'b0;
    n_vec++;
    if (mem_req_valid_o !== 1'b0) begin
      n_err++;
      $display("FAIL refill_req_drop got=%b want=0", mem_req_valid_o);
    end
    for (int k = 0; k < 4; k++) begin
      n_vec++;
      if ({we_way_mask_o, refill_done_o} !== 5'b0) begin
        n_err++;
        $display("FAIL refill_early_write beat=%0d got=%b want=00000", k,
                 {we_way_mask_o, refill_done_o});
      end
      mem_rsp_valid_i = 1'b1;
      mem_rsp_data_i  = beats[k];
      @(negedge clk);
    end
    mem_rsp_valid_i = 1'b0;
    n_vec++;
    if ({we_way_mask_o, w_bank_sel_o, w_bank_addr_o, wdata_tag_o, wdata_valid_o, refill_done_o,
         flush_done_o} !== {exp_victim, 2'd1, 8'h24, 17'h10000, 1'b1, 1'b1, 1'b0}) begin
      n_err++;
      $display("FAIL refill_strobe got mask=%b bank=%0d set=%h tag=%h v=%b rd=%b fd=%b want mask=%b bank=1 set=24 tag=10000 v=1 rd=1 fd=0",
               we_way_mask_o, w_bank_sel_o, w_bank_addr_o, wdata_tag_o, wdata_valid_o,
               refill_done_o, flush_done_o, exp_victim);
    end
    n_vec++;
    if (wdata_line_o !== {beats[3], beats[2], beats[1], beats[0]}) begin
      n_err++;
      $display("FAIL refill_line got=%h want=%h", wdata_line_o,
               {beats[3], beats[2], beats[1], beats[0]});
    end
    exp_victim = {exp_victim[2:0], exp_victim[3]};
    @(negedge clk);
    n_vec++;
    if ({we_way_mask_o, refill_done_o, miss_ready_o, busy_o} !== 7'b0000_010) begin
      n_err++;
      $display("FAIL refill_idle got=%b want=0000010",
               {we_way_mask_o, refill_done_o, miss_ready_o, busy_o});
    end
  endtask

  task automatic test_victim_rotation();
    logic [255:0] exp_line;
    logic [63:0]  b0;
    for (int j = 0; j < 5; j++) begin
      b0 = 64'hC000_0000_0000_0000 + 64'(j * 16);
      drive_miss(32'h0001_0000 + 32'(j * 32), b0);
      exp_line = {b0 + 64'd3, b0 + 64'd2, b0 + 64'd1, b0};
      n_vec++;
      if (obs_writes !== 1 || obs_mask !== exp_victim || obs_line !== exp_line) begin
        n_err++;
        $display("FAIL rotation miss=%0d got writes=%0d mask=%b want writes=1 mask=%b (line ok=%b)",
                 j, obs_writes, obs_mask, exp_victim, obs_line === exp_line);
      end
      exp_victim = {exp_victim[2:0], exp_victim[3]};
    end
  endtask

  task automatic test_stall_gapped();
    int           slots [7];
    logic [63:0]  beats [4];
    int           kk;
    slots = '{1, 0, 0, 1, 1, 0, 1};
    beats = '{64'hA0A0_0000_0000_00A0, 64'hB1B1_0000_0000_00B1,
              64'hC2C2_0000_0000_00C2, 64'hD3D3_0000_0000_00D3};
    miss_valid_i = 1'b1;
    miss_addr_i  = 32'h0000_ABCD;
    @(negedge clk);
    miss_valid_i = 1'b0;
    for (int i = 0; i < 6; i++) begin
      n_vec++;
      if (mem_req_valid_o !== 1'b1 || mem_req_addr_o !== 32'h0000_ABC0) begin
        n_err++;
        $display("FAIL stall_req cyc=%0d got v=%b addr=%h want v=1 addr=0000abc0",
                 i, mem_req_valid_o, mem_req_addr_o);
      end
      mem_req_ready_i = (i == 5);
      @(negedge clk);
    end
    mem_req_ready_i = 1'b0;
    kk = 0;
    for (int s = 0; s < 7; s++) begin
      n_vec++;
      if ({we_way_mask_o, refill_done_o, mem_req_valid_o} !== 6'b0) begin
        n_err++;
        $display("FAIL gapped_early slot=%0d got=%b want=000000", s,
                 {we_way_mask_o, refill_done_o, mem_req_valid_o});
      end
      mem_rsp_valid_i = (slots[s] == 1);
      mem_rsp_data_i  = (slots[s] == 1) ? beats[kk] : 64'hFFFF_FFFF_FFFF_FFFF;
      if (slots[s] == 1) kk++;
      @(negedge clk);
    end
    mem_rsp_valid_i = 1'b0;
    obs_writes = 0;
    for (int k = 0; k < 3; k++) begin
      if (we_way_mask_o !== 4'b0) begin
        obs_writes++;
        obs_mask = we_way_mask_o;
        obs_line = wdata_line_o;
        obs_tag  = wdata_tag_o;
        obs_set  = w_bank_addr_o;
        obs_bank = w_bank_sel_o;
      end
      @(negedge clk);
    end
    n_vec++;
    if (obs_writes !== 1 || obs_mask !== exp_victim) begin
      n_err++;
      $display("FAIL gapped_write got writes=%0d mask=%b want writes=1 mask=%b",
               obs_writes, obs_mask, exp_victim);
    end
    n_vec++;
    if ({obs_bank, obs_set, obs_tag} !== {2'd2, 8'h57, 17'd1} ||
        obs_line !== {beats[3], beats[2], beats[1], beats[0]}) begin
      n_err++;
      $display("FAIL gapped_data got bank=%0d set=%h tag=%h line=%h want bank=2 set=57 tag=1 line=%h",
               obs_bank, obs_set, obs_tag, obs_line, {beats[3], beats[2], beats[1], beats[0]});
    end
    exp_victim = {exp_victim[2:0], exp_victim[3]};
  endtask

  task automatic test_reset_mid_refill();
    int seen;
    logic [63:0] b0;
    miss_valid_i = 1'b1;
    miss_addr_i  = 32'h0000_4000;
    @(negedge clk);
    miss_valid_i = 1'b0;
    mem_req_ready_i = 1'b1;
    @(negedge clk);
    mem_req_ready_i = 1'b0;
    for (int k = 0; k < 2; k++) begin
      mem_rsp_valid_i = 1'b1;
      mem_rsp_data_i  = 64'h5555_0000_0000_0000 + 64'(k);
      @(negedge clk);
    end
    mem_rsp_valid_i = 1'b0;
    rst_ni = 1'b0;
    #1;
    n_vec++;
    if ({busy_o, we_way_mask_o, mem_req_valid_o, refill_done_o} !== 7'b1000000) begin
      n_err++;
      $display("FAIL midrst_async got=%b want=1000000",
               {busy_o, we_way_mask_o, mem_req_valid_o, refill_done_o});
    end
    seen = 0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      if (we_way_mask_o !== 4'b0 || wdata_valid_o !== 1'b0) seen++;
    end
    n_vec++;
    if (seen !== 0) begin
      n_err++;
      $display("FAIL midrst_no_write got strobe cycles=%0d want 0", seen);
    end
    rst_ni = 1'b1;
    #1;
    n_vec++;
    if ({we_way_mask_o, busy_o} !== 5'b00001) begin
      n_err++;
      $display("FAIL midrst_init got=%b want=00001", {we_way_mask_o, busy_o});
    end
    @(negedge clk);
    check_flush_sweep("reflush");
    exp_victim = 4'b0001;
    b0 = 64'h7700_0000_0000_0000;
    drive_miss(32'h0000_8040, b0);
    n_vec++;
    if (obs_writes !== 1 || obs_mask !== 4'b0001 ||
        obs_line !== {b0 + 64'd3, b0 + 64'd2, b0 + 64'd1, b0}) begin
      n_err++;
      $display("FAIL midrst_victim got writes=%0d mask=%b want writes=1 mask=0001 (line ok=%b)",
               obs_writes, obs_mask, obs_line === {b0 + 64'd3, b0 + 64'd2, b0 + 64'd1, b0});
    end
    exp_victim = {exp_victim[2:0], exp_victim[3]};
  endtask

  task automatic test_flush_priority();
    logic [63:0] b0;
    b0 = 64'h9900_0000_0000_0000;
    flush_i      = 1'b1;
    miss_valid_i = 1'b1;
    miss_addr_i  = 32'h1234_5660;
    #1;
    n_vec++;
    if (miss_ready_o !== 1'b0) begin
      n_err++;
      $display("FAIL flushprio_ready got=%b want=0", miss_ready_o);
    end
    @(negedge clk);
    flush_i = 1'b0;
    check_flush_sweep("prio");
    n_vec++;
    if (miss_ready_o !== 1'b1) begin
      n_err++;
      $display("FAIL flushprio_accept got=%b want=1", miss_ready_o);
    end
    @(negedge clk);
    miss_valid_i = 1'b0;
    n_vec++;
    if (mem_req_valid_o !== 1'b1 || mem_req_addr_o !== 32'h1234_5660) begin
      n_err++;
      $display("FAIL flushprio_req got v=%b addr=%h want v=1 addr=12345660",
               mem_req_valid_o, mem_req_addr_o);
    end
    finish_miss(b0);
    n_vec++;
    if (obs_writes !== 1 || obs_mask !== exp_victim) begin
      n_err++;
      $display("FAIL flushprio_victim got writes=%0d mask=%b want writes=1 mask=%b",
               obs_writes, obs_mask, exp_victim);
    end
    exp_victim = {exp_victim[2:0], exp_victim[3]};
  endtask

  initial begin
    test_reset();
    test_init_flush();
    test_refill();
    test_victim_rotation();
    test_stall_gapped();
    test_reset_mid_refill();
    test_flush_priority();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog got no completion want finish before 1000000 time units");
    $fatal(1, "watchdog expired");
  end

endmodule
